// File: rtl/jk_cmd_driver.sv
// jk_cmd_driver: command front-end for a JK flip-flop cell.
// Drives j/k for a counted number of cycles, then checks q.
module jk_cmd_driver #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             q_fb,
  input  logic             err_clr,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK
  } state_t;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic             exp_q;
  logic             exp_d;
  logic             acc;
  logic             last;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign acc       = cmd_ready && cmd_valid;
  assign last      = (rem == CNT_W'(1));

  // Final q expected once the op has been applied cmd_cnt times
  always_comb begin
    exp_d = q_fb;
    unique case (cmd_op)
      OP_HOLD:   exp_d = q_fb;
      OP_RESET:  exp_d = 1'b0;
      OP_SET:    exp_d = 1'b1;
      OP_TOGGLE: exp_d = q_fb ^ cmd_cnt[0];
      default:   exp_d = q_fb;
    endcase
  end

  // Command FSM with registered j/k/done/err
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rem   <= '0;
      exp_q <= 1'b0;
      j     <= 1'b0;
      k     <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (err_clr) begin
        err <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (acc) begin
            exp_q <= exp_d;
            if (cmd_cnt == '0) begin
              done <= 1'b1;
            end else begin
              state <= DRIVE;
              rem   <= cmd_cnt;
              j     <= cmd_op[1];
              k     <= cmd_op[0];
            end
          end
        end
        DRIVE: begin
          rem <= rem - CNT_W'(1);
          if (last) begin
            j     <= 1'b0;
            k     <= 1'b0;
            state <= CHECK;
          end
        end
        CHECK: begin
          done  <= 1'b1;
          state <= IDLE;
          // A mismatch overrides a same-edge clear
          if (q_fb != exp_q) begin
            err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          j     <= 1'b0;
          k     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_driver.sv
// tb_jk_cmd_driver: directed bench for jk_cmd_driver.
// A behavioural JK cell closes the q_fb loop.
module tb_jk_cmd_driver;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_cnt;
  logic       q_fb;
  logic       err_clr;
  logic       j;
  logic       k;
  logic       busy;
  logic       done;
  logic       err;

  logic q_m;
  logic mclr;
  logic fault;

  int passed;
  int total;

  jk_cmd_driver #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .q_fb      (q_fb),
    .err_clr   (err_clr),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream JK cell; fault forces q_fb high
  always @(posedge clk) begin
    if (mclr) q_m <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   q_m <= 1'b0;
        2'b10:   q_m <= 1'b1;
        2'b11:   q_m <= ~q_m;
        default: q_m <= q_m;
      endcase
    end
  end

  assign q_fb = fault ? 1'b1 : q_m;

  task automatic clr_model();
    mclr = 1'b1;
    @(negedge clk);
    mclr = 1'b0;
  endtask

  // Present a command at a negedge while idle; returns at negedge after E0
  task automatic send(input logic [1:0] op, input logic [3:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] o;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    o = {j, k, busy, done, err};
    total++;
    if (o !== 5'b0) $display("FAIL reset_outs got %b want 00000", o);
    else passed++;
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd_ready);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    clr_model();
    send(2'b11, 4'd5);
    for (int i = 0; i < 3; i++) begin
      o = {j, k, busy, done, err};
      total++;
      if (o !== 5'b11100) $display("FAIL reset_pre_drive%0d got %b want 11100", i, o);
      else passed++;
      if (i < 2) @(negedge clk);
    end
    #2 rst = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_cnt   = 4'd3;
    #1;
    o = {j, k, busy, done, err};
    total++;
    if (o !== 5'b0) $display("FAIL reset_abort got %b want 00000", o);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      o = {j, k, busy, done, err};
      total++;
      if (o !== 5'b0) $display("FAIL reset_hold%0d got %b want 00000", i, o);
      else passed++;
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = {cmd_ready, busy, done, err};
      total++;
      if (o !== 4'b1000) $display("FAIL reset_release%0d got %b want 1000", i, o);
      else passed++;
    end
  endtask

  task automatic test_set();
    logic [3:0] o;
    logic [3:0] e;
    clr_model();
    send(2'b10, 4'd3);
    for (int i = 0; i <= 4; i++) begin
      e = (i < 3) ? 4'b1010 : (i == 3) ? 4'b0010 : 4'b0001;
      o = {j, k, busy, done};
      total++;
      if (o !== e) $display("FAIL set_c%0d got %b want %b", i, o, e);
      else passed++;
      if (i == 3) begin
        total++;
        if (q_fb !== 1'b1) $display("FAIL set_qfb got %b want 1", q_fb);
        else passed++;
      end
      if (i < 4) @(negedge clk);
    end
    total++;
    if (err !== 1'b0) $display("FAIL set_err got %b want 0", err);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_toggle();
    logic [3:0] o;
    logic [3:0] e;
    int n;
    for (int r = 0; r < 2; r++) begin
      n = (r == 0) ? 5 : 4;
      clr_model();
      send(2'b11, 4'(n));
      for (int i = 0; i <= n + 1; i++) begin
        e = (i < n) ? 4'b1110 : (i == n) ? 4'b0010 : 4'b0001;
        o = {j, k, busy, done};
        total++;
        if (o !== e) $display("FAIL tog%0d_c%0d got %b want %b", n, i, o, e);
        else passed++;
        if (i == n) begin
          total++;
          if (q_fb !== ((n == 5) ? 1'b1 : 1'b0))
            $display("FAIL tog%0d_qfb got %b want %b", n, q_fb, (n == 5));
          else passed++;
        end
        if (i <= n) @(negedge clk);
      end
      total++;
      if (err !== 1'b0) $display("FAIL tog%0d_err got %b want 0", n, err);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_error();
    logic [1:0] o;
    clr_model();
    fault = 1'b1;
    send(2'b01, 4'd2);
    repeat (2) @(negedge clk);
    o = {done, err};
    total++;
    if (o !== 2'b00) $display("FAIL errinj_check got %b want 00", o);
    else passed++;
    @(negedge clk);
    o = {done, err};
    total++;
    if (o !== 2'b11) $display("FAIL errinj_done got %b want 11", o);
    else passed++;
    fault = 1'b0;
    @(negedge clk);
    send(2'b00, 4'd1);
    repeat (2) @(negedge clk);
    o = {done, err};
    total++;
    if (o !== 2'b11) $display("FAIL errinj_sticky got %b want 11", o);
    else passed++;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++;
    if (err !== 1'b0) $display("FAIL errinj_clr got %b want 0", err);
    else passed++;
  endtask

  task automatic test_collision();
    logic [1:0] o;
    clr_model();
    fault = 1'b1;
    send(2'b01, 4'd1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    fault   = 1'b0;
    o = {done, err};
    total++;
    if (o !== 2'b11) $display("FAIL collide got %b want 11", o);
    else passed++;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++;
    if (err !== 1'b0) $display("FAIL collide_clr got %b want 0", err);
    else passed++;
  endtask

  task automatic test_handshake();
    logic [4:0] o;
    logic [4:0] e;
    clr_model();
    send(2'b00, 4'd0);
    o = {j, k, busy, done, cmd_ready};
    total++;
    if (o !== 5'b00011) $display("FAIL hs_cnt0 got %b want 00011", o);
    else passed++;
    @(negedge clk);
    o = {j, k, busy, done, cmd_ready};
    total++;
    if (o !== 5'b00001) $display("FAIL hs_cnt0_after got %b want 00001", o);
    else passed++;
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_cnt   = 4'd2;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i <= 3; i++) begin
      e = (i < 2) ? 5'b10100 : (i == 2) ? 5'b00100 : 5'b00011;
      o = {j, k, busy, done, cmd_ready};
      total++;
      if (o !== e) $display("FAIL hs_held_c%0d got %b want %b", i, o, e);
      else passed++;
      if (i < 3) @(negedge clk);
    end
    cmd_op  = 2'b11;
    cmd_cnt = 4'd15;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      e = (i < 15) ? 5'b11100 : (i == 15) ? 5'b00100 : 5'b00011;
      o = {j, k, busy, done, cmd_ready};
      total++;
      if (o !== e) $display("FAIL hs_max_c%0d got %b want %b", i, o, e);
      else passed++;
      if (i < 16) @(negedge clk);
    end
    total++;
    if (err !== 1'b0) $display("FAIL hs_max_err got %b want 0", err);
    else passed++;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_cnt   = 4'd0;
    err_clr   = 1'b0;
    mclr      = 1'b1;
    fault     = 1'b0;
    test_reset();
    test_set();
    test_toggle();
    test_error();
    test_collision();
    test_handshake();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
